// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Parametrised register file with same-cycle write-to-read bypass,
//            an optional hardwired zero register and a per-register busy
//            scoreboard for read-after-write hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 4,
    parameter int ZERO_REG   = 0,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic [NUM_REGS-1:0]   busy_vec
);

    // One extra bit so that the register count itself is representable when
    // NUM_REGS is an exact power of two.
    localparam logic [ADDR_WIDTH:0] c_num_regs = (ADDR_WIDTH+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;

    logic w_wr_ok;
    logic w_iss_ok;

    // Qualify commit and issue: in range, not the hardwired zero register.
    // The commit is also gated by reset so no bypass leaks out during reset.
    always_comb begin
        w_wr_ok  = reset && write_enable
                   && ({1'b0, write_addr} < c_num_regs)
                   && !((ZERO_REG != 0) && (write_addr == '0));
        w_iss_ok = issue_valid
                   && ({1'b0, issue_addr} < c_num_regs)
                   && !((ZERO_REG != 0) && (issue_addr == '0));
    end

    // Register storage: writeback commits the qualified write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_ok && (write_addr == ADDR_WIDTH'(i))) begin
                    r_regs[i] <= write_data;
                end
            end
        end
    end

    // Scoreboard: a new issue takes priority over a completing commit, since
    // the newly issued instruction becomes the register's pending producer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_iss_ok && (issue_addr == ADDR_WIDTH'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_ok && (write_addr == ADDR_WIDTH'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Port A read: array lookup, then the same-cycle commit overrides both
    // the data and the hazard flag.
    always_comb begin
        read_data_a = '0;
        busy_a      = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((read_addr_a == ADDR_WIDTH'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                read_data_a = r_regs[i];
                busy_a      = r_busy[i];
            end
        end
        if (w_wr_ok && (write_addr == read_addr_a)) begin
            read_data_a = write_data;
            busy_a      = 1'b0;
        end
    end

    // Port B read: identical to port A, fully independent.
    always_comb begin
        read_data_b = '0;
        busy_b      = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((read_addr_b == ADDR_WIDTH'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                read_data_b = r_regs[i];
                busy_b      = r_busy[i];
            end
        end
        if (w_wr_ok && (write_addr == read_addr_b)) begin
            read_data_b = write_data;
            busy_b      = 1'b0;
        end
    end

    // Raw scoreboard state, without bypass masking.
    assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed self-checking bench for regfile_scoreboard, covering the
//            default configuration and a ZERO_REG=1, 6x32 configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic clk;
    logic reset;

    // Default configuration: 4 x 16, no zero register.
    logic [1:0]  a_ra, a_rb, a_wa, a_ia;
    logic        a_we, a_iv;
    logic [15:0] a_wd, a_rda, a_rdb;
    logic        a_ba, a_bb;
    logic [3:0]  a_bv;

    // Second configuration: 6 x 32, register 0 hardwired to zero.
    logic [2:0]  b_ra, b_rb, b_wa, b_ia;
    logic        b_we, b_iv;
    logic [31:0] b_wd, b_rda, b_rdb;
    logic        b_ba, b_bb;
    logic [5:0]  b_bv;

    int n_checks = 0;
    int n_errors = 0;

    regfile_scoreboard dut_a (
        .clk(clk), .reset(reset),
        .read_addr_a(a_ra), .read_addr_b(a_rb),
        .write_enable(a_we), .write_addr(a_wa), .write_data(a_wd),
        .issue_valid(a_iv), .issue_addr(a_ia),
        .read_data_a(a_rda), .read_data_b(a_rdb),
        .busy_a(a_ba), .busy_b(a_bb), .busy_vec(a_bv)
    );

    regfile_scoreboard #(.DATA_WIDTH(32), .NUM_REGS(6), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset),
        .read_addr_a(b_ra), .read_addr_b(b_rb),
        .write_enable(b_we), .write_addr(b_wa), .write_data(b_wd),
        .issue_valid(b_iv), .issue_addr(b_ia),
        .read_data_a(b_rda), .read_data_b(b_rdb),
        .busy_a(b_ba), .busy_b(b_bb), .busy_vec(b_bv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a write pending: nothing may commit or bypass.
        reset = 1'b0;
        a_ra = 2'd1; a_rb = 2'd0; a_we = 1'b1; a_wa = 2'd1; a_wd = 16'hBEEF;
        a_iv = 1'b0; a_ia = 2'd0;
        b_ra = 3'd0; b_rb = 3'd0; b_we = 1'b0; b_wa = 3'd0; b_wd = 32'd0;
        b_iv = 1'b0; b_ia = 3'd0;
        tick();
        tick();
        chk("rst_rda", 64'(a_rda), 64'h0);
        chk("rst_rdb", 64'(a_rdb), 64'h0);
        chk("rst_busy_a", 64'(a_ba), 64'h0);
        chk("rst_bv", 64'(a_bv), 64'h0);

        // Release reset, commit r1=1234 with same-cycle bypass.
        reset = 1'b1;
        a_wd  = 16'h1234;
        #1;
        chk("r1_bypass", 64'(a_rda), 64'h1234);
        tick();
        a_we = 1'b0;
        #1;
        chk("r1_stored", 64'(a_rda), 64'h1234);

        // Bypass: r2=00AA, then overwrite with 5555 read on both ports.
        a_we = 1'b1; a_wa = 2'd2; a_wd = 16'h00AA;
        tick();
        a_we = 1'b0; a_ra = 2'd2; a_rb = 2'd2;
        #1;
        chk("r2_old", 64'(a_rda), 64'h00AA);
        a_we = 1'b1; a_wd = 16'h5555;
        #1;
        chk("byp_a", 64'(a_rda), 64'h5555);
        chk("byp_b", 64'(a_rdb), 64'h5555);
        tick();
        a_we = 1'b0;
        #1;
        chk("byp_post_a", 64'(a_rda), 64'h5555);
        chk("byp_post_b", 64'(a_rdb), 64'h5555);

        // Scoreboard hazard on r3.
        a_iv = 1'b1; a_ia = 2'd3; a_ra = 2'd3;
        #1;
        chk("iss_same_cyc_busy", 64'(a_ba), 64'h0);
        tick();
        a_iv = 1'b0;
        #1;
        chk("iss_bv", 64'(a_bv), 64'h8);
        chk("iss_busy_a", 64'(a_ba), 64'h1);
        a_we = 1'b1; a_wa = 2'd3; a_wd = 16'h0F0F;
        #1;
        chk("cmt_busy_a", 64'(a_ba), 64'h0);
        chk("cmt_rda", 64'(a_rda), 64'h0F0F);
        chk("cmt_bv_pre", 64'(a_bv), 64'h8);
        tick();
        a_we = 1'b0;
        #1;
        chk("cmt_bv_post", 64'(a_bv), 64'h0);

        // Simultaneous issue and commit to r1: data written, busy kept.
        a_iv = 1'b1; a_ia = 2'd1;
        tick();
        #1;
        chk("sim_pre_bv", 64'(a_bv), 64'h2);
        a_we = 1'b1; a_wa = 2'd1; a_wd = 16'h7777;
        tick();
        a_iv = 1'b0; a_we = 1'b0; a_ra = 2'd1;
        #1;
        chk("sim_rda", 64'(a_rda), 64'h7777);
        chk("sim_bv", 64'(a_bv), 64'h2);
        chk("sim_busy_a", 64'(a_ba), 64'h1);
        a_we = 1'b1; a_wd = 16'h8888;
        tick();
        a_we = 1'b0;
        #1;
        chk("sim_clr_bv", 64'(a_bv), 64'h0);
        chk("sim_clr_rda", 64'(a_rda), 64'h8888);

        // Mid-operation reset: r0 gets data, then all four registers issued.
        a_we = 1'b1; a_wa = 2'd0; a_wd = 16'h1111;
        tick();
        a_we = 1'b0; a_iv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_ia = 2'(k);
            tick();
        end
        a_iv = 1'b0; a_ra = 2'd0; a_rb = 2'd3;
        #1;
        chk("mid_pre_bv", 64'(a_bv), 64'hF);
        chk("mid_pre_rda", 64'(a_rda), 64'h1111);
        chk("mid_pre_rdb", 64'(a_rdb), 64'h0F0F);
        reset = 1'b0;
        #1;
        chk("mid_rda", 64'(a_rda), 64'h0);
        chk("mid_rdb", 64'(a_rdb), 64'h0);
        chk("mid_bv", 64'(a_bv), 64'h0);
        chk("mid_busy_b", 64'(a_bb), 64'h0);
        tick();
        reset = 1'b1;
        tick();

        // Zero-register configuration.
        b_we = 1'b1; b_wa = 3'd0; b_wd = 32'hFFFFFFFF; b_ra = 3'd0;
        #1;
        chk("z_r0_byp", 64'(b_rda), 64'h0);
        tick();
        b_we = 1'b0;
        #1;
        chk("z_r0_read", 64'(b_rda), 64'h0);
        b_we = 1'b1; b_wa = 3'd5; b_wd = 32'hCAFEBABE;
        tick();
        b_we = 1'b0; b_ra = 3'd5;
        #1;
        chk("z_r5_read", 64'(b_rda), 64'hCAFEBABE);
        b_iv = 1'b1; b_ia = 3'd0;
        tick();
        b_ia = 3'd7;
        tick();
        b_iv = 1'b0;
        #1;
        chk("z_iss_ignored_bv", 64'(b_bv), 64'h0);
        b_iv = 1'b1; b_ia = 3'd5;
        tick();
        b_iv = 1'b0;
        #1;
        chk("z_r5_busy", 64'(b_ba), 64'h1);
        chk("z_r5_bv", 64'(b_bv), 64'h20);
        b_we = 1'b1; b_wa = 3'd7; b_wd = 32'h12345678; b_ra = 3'd7; b_rb = 3'd6;
        #1;
        chk("z_rd7", 64'(b_rda), 64'h0);
        chk("z_rd6", 64'(b_rdb), 64'h0);
        chk("z_busy6", 64'(b_bb), 64'h0);
        tick();
        b_we = 1'b0; b_rb = 3'd5;
        #1;
        chk("z_wr7_ignored_r5", 64'(b_rdb), 64'hCAFEBABE);
        chk("z_wr7_ignored_bv", 64'(b_bv), 64'h20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
